// File: rtl/time_of_day_counter.sv
// 24-hour HH:MM:SS time-of-day counter in packed BCD, advanced by edges of a 1 kHz data input.
// Define TOD_12H_EN to present a 12-hour hours_out and add a pm_out output.
module time_of_day_counter #(
  parameter int unsigned TICKS_PER_SEC = 1000,
  parameter int unsigned MS_W          = 10
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       clk_1khz_in,
  input  logic       run_in,
  input  logic       set_in,
  input  logic [1:0] sel_in,
  input  logic       inc_in,
  output logic [7:0] hours_out,
  output logic [7:0] minutes_out,
  output logic [7:0] seconds_out,
  output logic       sec_pulse_out,
`ifdef TOD_12H_EN
  output logic       pm_out,
`endif
  output logic       colon_out
);

  localparam logic [MS_W-1:0] MS_MAX  = MS_W'(TICKS_PER_SEC - 1);
  localparam logic [MS_W-1:0] MS_HALF = MS_W'(TICKS_PER_SEC / 2);

  logic            s0, s1, s2;
  logic            tick;
  logic [MS_W-1:0] ms_q, ms_d;
  logic [7:0]      hr_q, hr_d, min_q, min_d, sec_q, sec_d;
  logic [7:0]      hr_inc, min_inc, sec_inc;
  logic            hr_wrap, min_wrap, sec_wrap;
  logic            pulse_q, pulse_d;
  logic            colon_q, colon_d;

  // Returns {wrapped, next}; wraps to 00 after maxv, otherwise a BCD +1.
  function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] maxv);
    if (v == maxv)
      return 9'h100;
    if (v[3:0] == 4'd9)
      return {1'b0, v[7:4] + 4'd1, 4'd0};
    return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  assign tick = s1 & ~s2;

  always_comb begin
    {sec_wrap, sec_inc} = bcd_inc(sec_q, 8'h59);
    {min_wrap, min_inc} = bcd_inc(min_q, 8'h59);
    {hr_wrap,  hr_inc}  = bcd_inc(hr_q,  8'h23);
  end

  always_comb begin
    ms_d    = ms_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hr_d    = hr_q;
    pulse_d = 1'b0;
    if (set_in) begin
      ms_d = '0;
      if (inc_in) begin
        case (sel_in)
          2'd0:    sec_d = sec_inc;
          2'd1:    min_d = min_inc;
          2'd2:    hr_d  = hr_inc;
          default: ;
        endcase
      end
    end else if (run_in && tick) begin
      if (ms_q == MS_MAX) begin
        ms_d    = '0;
        pulse_d = 1'b1;
        sec_d   = sec_inc;
        if (sec_wrap) begin
          min_d = min_inc;
          if (min_wrap)
            hr_d = hr_inc;
        end
      end else begin
        ms_d = ms_q + 1'b1;
      end
    end
    colon_d = (ms_d < MS_HALF);
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      s0      <= 1'b0;
      s1      <= 1'b0;
      s2      <= 1'b0;
      ms_q    <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      hr_q    <= '0;
      pulse_q <= 1'b0;
      colon_q <= 1'b1;
    end else begin
      s0      <= clk_1khz_in;
      s1      <= s0;
      s2      <= s1;
      ms_q    <= ms_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      pulse_q <= pulse_d;
      colon_q <= colon_d;
    end
  end

  assign minutes_out   = min_q;
  assign seconds_out   = sec_q;
  assign sec_pulse_out = pulse_q;
  assign colon_out     = colon_q;

`ifdef TOD_12H_EN
  logic [4:0] hr_bin, hr12, hr12_lo;

  // Internal hours stay 0-23; only the displayed value is folded to 12, 1..11.
  always_comb begin
    hr_bin  = 5'(hr_q[7:4]) * 5'd10 + 5'(hr_q[3:0]);
    if (hr_bin == 5'd0)
      hr12 = 5'd12;
    else if (hr_bin > 5'd12)
      hr12 = hr_bin - 5'd12;
    else
      hr12 = hr_bin;
    hr12_lo = hr12 - 5'd10;
    if (hr12 >= 5'd10)
      hours_out = {4'd1, hr12_lo[3:0]};
    else
      hours_out = {4'd0, hr12[3:0]};
  end

  assign pm_out = (hr_bin >= 5'd12);
`else
  assign hours_out = hr_q;
`endif

endmodule

// File: doc/time_of_day_counter.md
Name: time_of_day_counter

Overview:
- Sits directly downstream of the 1 kHz clock divider in the clock design.
- Samples the divider's 1 kHz square wave as a data signal in the system clock domain and turns each rising edge into a one-cycle tick.
- Counts ticks into a 24-hour HH:MM:SS time of day in packed BCD, with a button-driven set mode.
- Feeds the seven-segment display driver: BCD digits, colon blink and a once-per-second pulse.

Parameters:
- TICKS_PER_SEC, 1000: number of 1 kHz rising edges per second.
- MS_W, 10: width of the sub-second tick counter; must satisfy 2^MS_W > TICKS_PER_SEC-1.

Ports:
- clk_in  input  1  system clock (100 MHz); the only clock in the block.
- reset_in  input  1  asynchronous, active-low reset.
- clk_1khz_in  input  1  1 kHz square wave from the divider; asynchronous-safe, treated as data.
- run_in  input  1  1 = time advances; 0 = frozen.
- set_in  input  1  1 = set mode.
- sel_in  input  2  field selected in set mode: 0 = seconds, 1 = minutes, 2 = hours, 3 = none.
- inc_in  input  1  single-cycle pulse, synchronous to clk_in (already debounced); increments the selected field.
- hours_out  output  8  BCD {tens, ones}, 00–23.
- minutes_out  output  8  BCD {tens, ones}, 00–59.
- seconds_out  output  8  BCD {tens, ones}, 00–59.
- sec_pulse_out  output  1  one-cycle pulse on each natural seconds increment.
- colon_out  output  1  high during the first half of each second.

Behaviour:
- Reset (async, reset_in=0):
  - sync chain s0/s1/s2 = 0; ms_cnt = 0.
  - hours, minutes, seconds = 0x00.
  - sec_pulse_out = 0; colon_out = 1.
  - Reset mid-operation clears everything immediately, with no clock required.
- Edge detect:
  - clk_1khz_in -> s0 -> s1 -> s2, one register each.
  - tick = s1 & ~s2.
  - An input rise sampled at edge k gives tick high during cycle k+1–k+2; counters update at edge k+2.
  - Exactly one tick per input rising edge; a held-high input never retriggers.
- Counting (run_in=1, set_in=0, tick=1):
  - ms_cnt increments.
  - When ms_cnt == TICKS_PER_SEC-1: ms_cnt <= 0, seconds increments, sec_pulse_out = 1 for that single cycle.
- BCD carry chain, all in the same cycle:
  - Ones digit 9 -> 0 with carry into tens.
  - Seconds 59 -> 00 carries into minutes; minutes 59 -> 00 carries into hours.
  - Hours 23 -> 00, no further carry; 23:59:59 + 1 s = 00:00:00.
  - BCD digits never hold A–F.
- run_in=0: ticks ignored; ms_cnt and time hold their values; sec_pulse_out = 0.
- Set mode (set_in=1):
  - ms_cnt forced to 0 each cycle; ticks ignored; sec_pulse_out = 0.
  - An inc_in pulse increments only the selected field, effective at the next edge.
  - Seconds and minutes wrap 59 -> 00; hours wrap 23 -> 00; there is no carry into other fields.
  - sel_in=3: inc_in ignored.
  - sel_in changing in the same cycle as inc_in: the new sel_in value is used.
- Leaving set mode: counting resumes from ms_cnt=0, so the first natural second increment occurs TICKS_PER_SEC ticks later.
- inc_in with set_in=0: ignored.
- tick in the same cycle that set_in rises: set mode wins; no increment.
- colon_out: registered; 1 when the next ms_cnt < TICKS_PER_SEC/2, else 0. It follows ms_cnt with one cycle of latency.

Optional Feature:
- Macro TOD_12H_EN.
- Defined:
  - Adds output pm_out (1 bit, reset 0).
  - hours_out shows 12, 01..11; internal hours stay 0–23.
  - Display hour = 12 when internal hour is 0 or 12, else internal mod 12, in BCD.
  - pm_out = 1 for internal hours 12–23.
  - Set mode still steps the internal 0–23 value, so pm_out toggles on the 11 -> 12 and 23 -> 00 wraps.
- Undefined: no pm_out port; hours_out is the 24-hour BCD value 00–23.

Test Plan:
- Reset asserted mid-count at 12:34:56 -> outputs 00:00:00 and colon_out = 1 with no clk_in edge; after release, time and outputs stay at 00:00:00 until the first ticks.
- Drive 1000 rising edges on clk_1khz_in (period 100000 clk_in cycles) -> seconds_out = 0x01; sec_pulse_out high for exactly 1 cycle, 2 cycles after the 1000th sampled edge.
- Preload via set mode to 23:59:59, then 1000 ticks -> 00:00:00. Separately, 09:59:59 -> 10:00:00 (BCD carries through every digit).
- set_in=1, sel_in=1, minutes 58, three inc_in pulses -> minutes 59, 00, 01; hours unchanged; ticks during set cause no change.
- run_in=0 for 2500 ticks -> time and ms_cnt unchanged. run_in=1 again -> next second after the remaining ticks only; colon_out is high for 500 ticks and low for 500.
- TOD_12H_EN build: internal 11:59:59, +1 s -> hours_out 0x12, pm_out 1; from 23:59:59 +1 s -> hours_out 0x12, pm_out 0.
